// File: rtl/ecg_sample_sequencer_pkg.sv
// Shared types and constants for the ECG waveform player.
// Holds the FSM state encoding and the DAC code range limits.
package ecg_sample_sequencer_pkg;

  localparam int DAC_W      = 12;
  localparam int GAIN_UNITY = 128;
  localparam int DAC_MAX    = 4095;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    CALC,
    PEND
  } state_t;

endpackage

// File: rtl/ecg_scale_sat.sv
// Combinational gain (Q1.7) and signed offset stage, clamped to the DAC code range.
module ecg_scale_sat
  import ecg_sample_sequencer_pkg::*;
(
  input  logic        [DAC_W-1:0] i_sample,
  input  logic        [7:0]       i_gain,
  input  logic signed [12:0]      i_offset,
  output logic        [DAC_W-1:0] o_result
);

  logic        [19:0] w_prod;
  logic        [12:0] w_scaled;
  logic signed [14:0] w_sum;

  assign w_prod   = {8'd0, i_sample} * {12'd0, i_gain};
  assign w_scaled = 13'(w_prod >> $clog2(GAIN_UNITY));
  assign w_sum    = $signed({2'b00, w_scaled}) + $signed({{2{i_offset[12]}}, i_offset});

  // A non-negative sum with either bit 13 or 12 set is above full scale.
  always_comb begin
    o_result = w_sum[11:0];
    if (w_sum[14]) begin
      o_result = '0;
    end else if (w_sum[13:12] != 2'b00) begin
      o_result = DAC_W'(DAC_MAX);
    end
  end

endmodule

// File: rtl/ecg_sample_sequencer.sv
// Fixed-rate ECG player: fetches one ROM sample per tick, scales it and hands it
// to the DAC driver, updating dac_data only while the driver reports busy.
module ecg_sample_sequencer
  import ecg_sample_sequencer_pkg::*;
#(
  parameter int          TICK_DIV   = 50000,
  parameter int          TABLE_LEN  = 500,
  parameter int          ADDR_W     = 9,
  parameter logic [11:0] RESET_CODE = 12'd2048
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [7:0]         gain,
  input  logic signed [12:0] offset,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [11:0]        rom_data,
  input  logic               dac_busy,
  output logic [11:0]        dac_data,
  output logic               pending,
  output logic [7:0]         overrun_cnt
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0]  r_tickCnt;
  logic              w_tick;
  logic              r_busyMeta;
  logic              r_busyS;
  state_t            r_state;
  logic [ADDR_W-1:0] r_romAddr;
  logic [DAC_W-1:0]  r_romSample;
  logic [DAC_W-1:0]  r_held;
  logic [DAC_W-1:0]  r_dacData;
  logic              r_pending;
  logic [7:0]        r_overrunCnt;
  logic [DAC_W-1:0]  w_scaled;

  assign w_tick = enable && (r_tickCnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || !enable || w_tick) begin
      r_tickCnt <= '0;
    end else begin
      r_tickCnt <= r_tickCnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busyMeta <= 1'b0;
      r_busyS    <= 1'b0;
    end else begin
      r_busyMeta <= dac_busy;
      r_busyS    <= r_busyMeta;
    end
  end

  ecg_scale_sat u_scale (
    .i_sample (r_romSample),
    .i_gain   (gain),
    .i_offset (offset),
    .o_result (w_scaled)
  );

  // Any tick that finds the FSM busy (including the commit cycle) is dropped and counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_romAddr    <= '0;
      r_romSample  <= '0;
      r_held       <= '0;
      r_dacData    <= RESET_CODE;
      r_pending    <= 1'b0;
      r_overrunCnt <= '0;
    end else begin
      if (w_tick && (r_state != IDLE) && (r_overrunCnt != 8'hFF)) begin
        r_overrunCnt <= r_overrunCnt + 8'd1;
      end
      case (r_state)
        IDLE:  if (w_tick) r_state <= FETCH;
        FETCH: r_state <= WAIT;
        WAIT: begin
          r_romSample <= rom_data;
          r_state     <= CALC;
        end
        CALC: begin
          r_held    <= w_scaled;
          r_pending <= 1'b1;
          r_state   <= PEND;
        end
        PEND: begin
          if (r_busyS) begin
            r_dacData <= r_held;
            r_pending <= 1'b0;
            r_romAddr <= (r_romAddr == ADDR_W'(TABLE_LEN - 1)) ? '0 : r_romAddr + ADDR_W'(1);
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rom_addr    = r_romAddr;
  assign dac_data    = r_dacData;
  assign pending     = r_pending;
  assign overrun_cnt = r_overrunCnt;

endmodule

// File: tb/tb_ecg_sample_sequencer.sv
// Scoreboard bench for ecg_sample_sequencer: expected commits are queued at stimulus
// time and a posedge monitor pops and compares them whenever pending drops.
module tb_ecg_sample_sequencer;

  localparam int TICK_DIV  = 20;
  localparam int TABLE_LEN = 4;
  localparam int ADDR_W    = 2;

  logic               clk;
  logic               rst_n;
  logic               enable;
  logic [7:0]         gain;
  logic signed [12:0] offset;
  logic [ADDR_W-1:0]  rom_addr;
  logic [11:0]        rom_data;
  logic               dac_busy;
  logic [11:0]        dac_data;
  logic               pending;
  logic [7:0]         overrun_cnt;

  logic [11:0] romMem [0:TABLE_LEN-1];

  typedef struct {
    int data;
    int addr;
  } exp_t;

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;
  int   popCount    = 0;
  int   expAddr     = 0;
  int   nextExp     = 0;
  int   lastExp     = 2048;
  int   curAddr     = 0;
  logic prevPending = 1'b0;

  ecg_sample_sequencer #(
    .TICK_DIV   (TICK_DIV),
    .TABLE_LEN  (TABLE_LEN),
    .ADDR_W     (ADDR_W),
    .RESET_CODE (12'd2048)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .gain        (gain),
    .offset      (offset),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .dac_busy    (dac_busy),
    .dac_data    (dac_data),
    .pending     (pending),
    .overrun_cnt (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= romMem[rom_addr];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int refScale(int sample, int g, int off);
    int v = (sample * g) / 128 + off;
    if (v < 0) return 0;
    if (v > 4095) return 4095;
    return v;
  endfunction

  task automatic checkOutput(input string name, input integer actual, input integer expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // A pending 1->0 transition outside reset is a commit; it must match the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n === 1'b1 && prevPending === 1'b1 && pending === 1'b0) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpectedCommit: got commit of %0d, required none", dac_data);
      end else begin
        e = expQ.pop_front();
        checkOutput("commitData", dac_data, e.data);
        checkOutput("commitAddr", rom_addr, e.addr);
        popCount++;
      end
    end
    prevPending = pending;
  end

  task automatic applyStimulus(input int sample, input int g, input int off);
    romMem[expAddr] = 12'(sample);
    gain    = 8'(g);
    offset  = 13'(off);
    nextExp = refScale(sample, g, off);
    expAddr = (expAddr + 1) % TABLE_LEN;
    expQ.push_back('{nextExp, expAddr});
  endtask

  task automatic waitPending();
    int n = 0;
    while (pending !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pendingRise", pending, 1);
  endtask

  task automatic commitWithBusy();
    lastExp  = nextExp;
    dac_busy = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput("holdBeforeFall", dac_data, lastExp);
      @(negedge clk);
    end
    dac_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("holdAfterFall", dac_data, lastExp);
      @(negedge clk);
    end
  endtask

  task automatic runOne(input int sample, input int g, input int off);
    applyStimulus(sample, g, off);
    enable = 1'b1;
    repeat (TICK_DIV) @(negedge clk);
    enable = 1'b0;
    waitPending();
    commitWithBusy();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; dac_busy = 1'b0; gain = 8'd128; offset = '0;
    for (int i = 0; i < TABLE_LEN; i++) romMem[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("resetDacData", dac_data, 2048);
    checkOutput("resetPending", pending, 0);
    checkOutput("resetOverrun", overrun_cnt, 0);
    checkOutput("resetRomAddr", rom_addr, 0);

    // Free-running playback across the table wrap with a periodically dipping busy.
    romMem[0] = 12'd100; romMem[1] = 12'd2000; romMem[2] = 12'd4095; romMem[3] = 12'd0;
    expQ.push_back('{100, 1});
    expQ.push_back('{2000, 2});
    expQ.push_back('{4095, 3});
    expQ.push_back('{0, 0});
    expQ.push_back('{100, 1});
    expAddr = 1;
    nextExp = 100;
    enable = 1'b1;
    for (int cyc = 0; cyc < 600 && popCount < 5; cyc++) begin
      dac_busy = ((cyc % 30) >= 3);
      @(negedge clk);
    end
    enable = 1'b0;
    dac_busy = 1'b0;
    lastExp = 100;
    checkOutput("playbackCommits", popCount, 5);
    checkOutput("playbackOverrun", overrun_cnt, 0);
    repeat (5) @(negedge clk);

    runOne(4095, 255, 0);
    runOne(100, 128, -500);
    runOne(1000, 64, 300);
    for (int i = 0; i < 8; i++) begin
      runOne($urandom_range(4095), $urandom_range(255), int'($urandom_range(8191)) - 4096);
    end
    checkOutput("randomOverrun", overrun_cnt, 0);

    // Busy held low: one sample waits, four ticks are dropped, later gain/offset ignored.
    curAddr = expAddr;
    applyStimulus($urandom_range(4095), $urandom_range(255), int'($urandom_range(8191)) - 4096);
    enable = 1'b1;
    repeat (30) @(negedge clk);
    gain = 8'($urandom_range(255));
    offset = 13'($urandom_range(8191));
    repeat (70) @(negedge clk);
    enable = 1'b0;
    checkOutput("stallPending", pending, 1);
    checkOutput("stallDacData", dac_data, lastExp);
    checkOutput("stallOverrun", overrun_cnt, 4);
    checkOutput("stallRomAddr", rom_addr, curAddr);
    commitWithBusy();
    repeat (30) @(negedge clk);
    checkOutput("stallOverrunAfter", overrun_cnt, 4);

    // Reset while a sample is pending abandons it.
    applyStimulus($urandom_range(4095), 128, 0);
    enable = 1'b1;
    repeat (TICK_DIV) @(negedge clk);
    enable = 1'b0;
    waitPending();
    rst_n = 1'b0;
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    expAddr = 0;
    lastExp = 2048;
    checkOutput("midResetDacData", dac_data, 2048);
    checkOutput("midResetPending", pending, 0);
    checkOutput("midResetOverrun", overrun_cnt, 0);
    checkOutput("midResetRomAddr", rom_addr, 0);
    dac_busy = 1'b1;
    repeat (10) @(negedge clk);
    dac_busy = 1'b0;
    checkOutput("postResetDacData", dac_data, 2048);
    checkOutput("postResetPending", pending, 0);
    repeat (4) @(negedge clk);

    // Enable dropped one clock after a tick: that sample completes, nothing else starts.
    applyStimulus($urandom_range(4095), $urandom_range(255), int'($urandom_range(8191)) - 4096);
    enable = 1'b1;
    repeat (TICK_DIV + 1) @(negedge clk);
    enable = 1'b0;
    waitPending();
    commitWithBusy();
    dac_busy = 1'b1;
    repeat (60) @(negedge clk);
    dac_busy = 1'b0;
    checkOutput("disabledPending", pending, 0);
    checkOutput("disabledRomAddr", rom_addr, expAddr);
    checkOutput("disabledDacData", dac_data, lastExp);
    repeat (5) @(negedge clk);

    // Re-enable: the first tick lands TICK_DIV clocks later, pending follows 3 clocks after.
    applyStimulus($urandom_range(4095), $urandom_range(255), int'($urandom_range(8191)) - 4096);
    enable = 1'b1;
    repeat (TICK_DIV + 2) @(negedge clk);
    checkOutput("reenableEarly", pending, 0);
    @(negedge clk);
    enable = 1'b0;
    checkOutput("reenableOnTime", pending, 1);
    commitWithBusy();

    repeat (10) @(negedge clk);
    checkOutput("queueDrained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
